// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver, 8-bit LSB-first frames, one-cycle
//            data_valid / stop_err / par_err pulses. Optional parity stage
//            compiled in with `define UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      stop_err,
    output logic                      par_err
);

    localparam int                        BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]      LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE     = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic                      sync1_q, rx_s_q;
    state_t                    state_q, state_d;
    logic                      armed_q, armed_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      stop_err_q, stop_err_d;
    logic                      par_err_q, par_err_d;
    logic                      par_bad_q, par_bad_d;

    logic                      w_mid, w_last;

    assign w_mid  = (edge_cnt_q == ((presc_q >> 1) - P_ONE));
    assign w_last = (edge_cnt_q == (presc_q - P_ONE));

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | rx_s_q;
        presc_d      = presc_q;
        edge_cnt_d   = edge_cnt_q + P_ONE;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        par_err_d    = 1'b0;
        par_bad_d    = par_bad_q;

        case (state_q)
            S_IDLE: begin
                // The falling-edge cycle itself is edge 0 of the start bit.
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                par_bad_d  = 1'b0;
                if (armed_q && !rx_s_q) begin
                    state_d    = S_START;
                    presc_d    = Prescale;
                    edge_cnt_d = P_ONE;
                end
            end
            S_START: begin
                if (w_mid && rx_s_q) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (w_last) begin
                    state_d    = S_DATA;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    shift_d[bit_cnt_q] = rx_s_q;
                end
                if (w_last) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // Expected bit makes the total ones count even (PAR_TYP=0) or odd.
                if (w_mid) begin
                    par_bad_d = (rx_s_q != ((^shift_q) ^ PAR_TYP));
                end
                if (w_last) begin
                    state_d    = S_STOP;
                    edge_cnt_d = '0;
                end
            end
`endif
            S_STOP: begin
                // Leave right after the sample so a zero-gap next start is caught.
                if (w_mid) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    par_err_d  = par_bad_q;
                    if (!rx_s_q) begin
                        stop_err_d = 1'b1;
                        armed_d    = 1'b0;
                    end else if (!par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            presc_q      <= '0;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            par_err_q    <= 1'b0;
            par_bad_q    <= 1'b0;
        end else begin
            sync1_q      <= RX_IN;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            armed_q      <= armed_d;
            presc_q      <= presc_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            stop_err_q   <= stop_err_d;
            par_err_q    <= par_err_d;
            par_bad_q    <= par_bad_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign stop_err   = stop_err_q;

`ifdef UART_RX_PARITY_EN
    assign par_err = par_err_q;
`else
    // Parity hardware is compiled out; the related flops never leave reset.
    logic unused_parity;
    assign unused_parity = PAR_TYP ^ par_err_q;
    assign par_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       stop_err;
    logic       par_err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .stop_err   (stop_err),
        .par_err    (par_err)
    );

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int p     = 16;

    int         dv_cnt, se_cnt, pe_cnt;
    int         dv_cyc, start_cyc;
    logic [7:0] byte_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            byte_q.push_back(P_DATA);
        end
        if (stop_err === 1'b1) se_cnt = se_cnt + 1;
        if (par_err === 1'b1)  pe_cnt = pe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        dv_cnt = 0;
        se_cnt = 0;
        pe_cnt = 0;
        dv_cyc = -1;
        byte_q.delete();
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PAR_TYP, p);
`endif
        drive_bit(stop, p);
    endtask

    task automatic set_prescale(input int v);
        p        = v;
        Prescale = 6'(v);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RX_IN = 1'b1;
        PAR_TYP = 1'b0;
        set_prescale(16);
        clear_mon();
        repeat (4) @(posedge CLK);
        #1;
        n_cmp++; if (P_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_p_data: got %h want 00", P_DATA); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        n_cmp++; if (stop_err !== 1'b0) begin n_bad++; $display("FAIL reset_stop_err: got %b want 0", stop_err); end
        n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL reset_par_err: got %b want 0", par_err); end
        RST = 1'b1;
        drive_bit(1'b1, 8);
    endtask

    task automatic test_single_byte();
        set_prescale(16);
        clear_mon();
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 4);
        n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'hA5) begin n_bad++; $display("FAIL single_p_data: got %h want a5", P_DATA); end
        n_cmp++; if (se_cnt !== 0) begin n_bad++; $display("FAIL single_stop_err: got %0d want 0", se_cnt); end
        // Two synchronizer cycles ahead of T0, then T0 + (FRAME_BITS-1)*P + P/2.
        n_cmp++;
        if (dv_cyc - start_cyc !== 2 + (FRAME_BITS - 1) * 16 + 8) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want %0d", dv_cyc - start_cyc, 2 + (FRAME_BITS - 1) * 16 + 8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        set_prescale(8);
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        drive_bit(1'b1, 16);
        n_cmp++; if (dv_cnt !== 3) begin n_bad++; $display("FAIL b2b_dv_count: got %0d want 3", dv_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (byte_q.size() <= i) begin
                n_bad++; $display("FAIL b2b_byte%0d: got none want %h", i, exp_b[i]);
            end else if (byte_q[i] !== exp_b[i]) begin
                n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, byte_q[i], exp_b[i]);
            end
        end
        n_cmp++; if (se_cnt + pe_cnt !== 0) begin n_bad++; $display("FAIL b2b_errors: got %0d want 0", se_cnt + pe_cnt); end
    endtask

    task automatic test_start_glitch();
        set_prescale(16);
        clear_mon();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        n_cmp++; if (dv_cnt + se_cnt + pe_cnt !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", dv_cnt + se_cnt + pe_cnt); end
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 4);
        n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL glitch_next_dv: got %0d want 1", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'h5A) begin n_bad++; $display("FAIL glitch_next_data: got %h want 5a", P_DATA); end
    endtask

    task automatic test_framing_error();
        set_prescale(16);
        clear_mon();
        send_frame(8'h81, 1'b0);
        drive_bit(1'b0, 40 * 16);
        n_cmp++; if (se_cnt !== 1) begin n_bad++; $display("FAIL frame_stop_err_count: got %0d want 1", se_cnt); end
        n_cmp++; if (dv_cnt !== 0) begin n_bad++; $display("FAIL frame_no_dv: got %0d want 0", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'h5A) begin n_bad++; $display("FAIL frame_p_data_held: got %h want 5a", P_DATA); end
        drive_bit(1'b1, 32);
        send_frame(8'h42, 1'b1);
        drive_bit(1'b1, 4);
        n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL frame_recover_dv: got %0d want 1", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'h42) begin n_bad++; $display("FAIL frame_recover_data: got %h want 42", P_DATA); end
        n_cmp++; if (se_cnt !== 1) begin n_bad++; $display("FAIL frame_recover_stop_err: got %0d want 1", se_cnt); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic pbit);
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        drive_bit(pbit, p);
        drive_bit(1'b1, p);
    endtask

    task automatic test_parity();
        set_prescale(16);
        PAR_TYP = 1'b0;
        clear_mon();
        send_frame_par(8'h07, 1'b1);
        drive_bit(1'b1, 4);
        n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL par_good_dv: got %0d want 1", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'h07) begin n_bad++; $display("FAIL par_good_data: got %h want 07", P_DATA); end
        n_cmp++; if (pe_cnt !== 0) begin n_bad++; $display("FAIL par_good_par_err: got %0d want 0", pe_cnt); end
        clear_mon();
        send_frame_par(8'h07, 1'b0);
        drive_bit(1'b1, 4);
        n_cmp++; if (pe_cnt !== 1) begin n_bad++; $display("FAIL par_bad_par_err: got %0d want 1", pe_cnt); end
        n_cmp++; if (dv_cnt !== 0) begin n_bad++; $display("FAIL par_bad_dv: got %0d want 0", dv_cnt); end
        n_cmp++; if (se_cnt !== 0) begin n_bad++; $display("FAIL par_bad_stop_err: got %0d want 0", se_cnt); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hF0;
        set_prescale(16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, p);
        for (int i = 0; i < 4; i++) drive_bit(d[i], p);
        RX_IN = d[4];
        repeat (8) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        n_cmp++; if (P_DATA !== 8'h00) begin n_bad++; $display("FAIL midrst_p_data: got %h want 00", P_DATA); end
        n_cmp++; if ({data_valid, stop_err, par_err} !== 3'b000) begin n_bad++; $display("FAIL midrst_pulses: got %b want 000", {data_valid, stop_err, par_err}); end
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        clear_mon();
        drive_bit(1'b1, 3 * 16);
        n_cmp++; if (dv_cnt + se_cnt + pe_cnt !== 0) begin n_bad++; $display("FAIL midrst_spurious: got %0d want 0", dv_cnt + se_cnt + pe_cnt); end
        send_frame(8'hC3, 1'b1);
        drive_bit(1'b1, 4);
        n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL midrst_next_dv: got %0d want 1", dv_cnt); end
        n_cmp++; if (P_DATA !== 8'hC3) begin n_bad++; $display("FAIL midrst_next_data: got %h want c3", P_DATA); end
        n_cmp++; if (se_cnt + pe_cnt !== 0) begin n_bad++; $display("FAIL midrst_next_errors: got %0d want 0", se_cnt + pe_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_start_glitch();
        test_framing_error();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
